// File: rtl/frame_buffer_reader_pkg.sv
// Shared constants and types for the downsampled double-buffered frame buffer.
package fb_pkg;
  localparam int unsigned HCOUNT       = 160;
  localparam int unsigned VCOUNT       = 90;
  localparam int unsigned FRAME_PIXELS = HCOUNT * VCOUNT;
  localparam int unsigned FB_ADDR_W    = $clog2(2 * FRAME_PIXELS);

  typedef enum logic {
    FRONT_STABLE,
    SWAP_PENDING
  } swap_state_t;
endpackage

// File: rtl/frame_buffer_reader_if.sv
// BRAM read port between the frame buffer reader (master) and the BRAM (slave).
interface frame_buffer_reader_if #(
  parameter int unsigned ADDR_W = fb_pkg::FB_ADDR_W,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] addr_out;
  logic [DATA_W-1:0] bram_data_in;

  modport master (output addr_out, input bram_data_in);
  modport slave  (input addr_out, output bram_data_in);
endinterface

// File: rtl/frame_buffer_reader_sig_delay.sv
// Fixed-depth shift register with synchronous clear, used to realign side signals.
module sig_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] delayed
);
  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= sig;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign delayed = stage[DEPTH-1];
endmodule

// File: rtl/frame_buffer_reader.sv
// Read side of the double-buffered downsampled frame buffer: coordinate mapping,
// BRAM addressing, pixel/timing realignment and front/back buffer swapping.
module frame_buffer_reader #(
  parameter int unsigned HCOUNT       = fb_pkg::HCOUNT,
  parameter int unsigned VCOUNT       = fb_pkg::VCOUNT,
  parameter int unsigned SCALE_LOG2   = 3,
  parameter int unsigned BRAM_LATENCY = 2,
  parameter int unsigned PIXEL_WIDTH  = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   active_draw_in,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   new_frame_in,
  input  logic                   wr_frame_done_in,
  frame_buffer_reader_if.master  bram,
  output logic [PIXEL_WIDTH-1:0] pixel_out,
  output logic                   active_draw_out,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic                   wr_buf_sel_out,
  output logic [7:0]             frames_dropped_out
);
  import fb_pkg::*;

  localparam int unsigned LAT    = 3 + BRAM_LATENCY;
  localparam int unsigned ADDR_W = $clog2(2 * HCOUNT * VCOUNT);
  localparam logic [ADDR_W-1:0] FRAME_OFFSET = ADDR_W'(HCOUNT * VCOUNT);

  swap_state_t state, state_nxt;
  logic        rd_buf, rd_buf_nxt;
  logic [7:0]  dropped_nxt;

  logic [10:0] x_next, x_q;
  logic [9:0]  y_next, y_q;
  logic        inb_next, inb_q, inb_s2, inb_data;
  logic [ADDR_W-1:0] addr_calc, addr_q;

  // Stage 1: downscale display coordinates and flag in-buffer pixels.
  assign x_next   = hcount_in >> SCALE_LOG2;
  assign y_next   = vcount_in >> SCALE_LOG2;
  assign inb_next = active_draw_in && (x_next < 11'(HCOUNT)) && (y_next < 10'(VCOUNT));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x_q   <= '0;
      y_q   <= '0;
      inb_q <= 1'b0;
    end else begin
      x_q   <= x_next;
      y_q   <= y_next;
      inb_q <= inb_next;
    end
  end

  // rd_buf is sampled here; swaps occur at frame start, so only blanking
  // addresses already in flight see the new buffer and no flush is required.
  assign addr_calc = (rd_buf ? FRAME_OFFSET : '0)
                   + ADDR_W'(y_q) * ADDR_W'(HCOUNT)
                   + ADDR_W'(x_q);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q <= '0;
      inb_s2 <= 1'b0;
    end else begin
      addr_q <= inb_q ? addr_calc : '0;
      inb_s2 <= inb_q;
    end
  end

  assign bram.addr_out = addr_q;

  sig_delay #(.WIDTH(1), .DEPTH(BRAM_LATENCY)) u_inb_delay (
    .clk     (clk_in),
    .rst     (rst_in),
    .sig     (inb_s2),
    .delayed (inb_data)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) pixel_out <= '0;
    else        pixel_out <= inb_data ? bram.bram_data_in : '0;
  end

  sig_delay #(.WIDTH(3), .DEPTH(LAT)) u_timing_delay (
    .clk     (clk_in),
    .rst     (rst_in),
    .sig     ({active_draw_in, hsync_in, vsync_in}),
    .delayed ({active_draw_out, hsync_out, vsync_out})
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state              <= FRONT_STABLE;
      rd_buf             <= 1'b0;
      frames_dropped_out <= '0;
    end else begin
      state              <= state_nxt;
      rd_buf             <= rd_buf_nxt;
      frames_dropped_out <= dropped_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_buf_nxt  = rd_buf;
    dropped_nxt = frames_dropped_out;
    case (state)
      FRONT_STABLE: begin
        if (wr_frame_done_in && new_frame_in) rd_buf_nxt = ~rd_buf;
        else if (wr_frame_done_in)            state_nxt  = SWAP_PENDING;
      end
      SWAP_PENDING: begin
        if (new_frame_in) begin
          rd_buf_nxt = ~rd_buf;
          state_nxt  = FRONT_STABLE;
        end else if (wr_frame_done_in && frames_dropped_out != 8'hFF) begin
          dropped_nxt = frames_dropped_out + 8'd1;
        end
      end
      default: state_nxt = FRONT_STABLE;
    endcase
  end

  assign wr_buf_sel_out = ~rd_buf;
endmodule
